// File: rtl/state_spec_pkg.sv
// Shared codes, flag mapping and FSM state type for the state/flag driver.
// Imported by state_spec_driver and state_flag_checker.
package state_spec_pkg;

    localparam logic [1:0] ST_00      = 2'b00;
    localparam logic [1:0] ST_01      = 2'b01;
    localparam logic [1:0] ST_11      = 2'b11;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    localparam logic [1:0] FLAG_LOW_STATES = 2'b10;
    localparam logic [1:0] FLAG_HIGH_STATE = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        S00,
        S01,
        S11
    } fsm_state_t;

    function automatic logic [1:0] expected_flag(input logic [1:0] code);
        return (code == ST_11) ? FLAG_HIGH_STATE : FLAG_LOW_STATES;
    endfunction

    // IDLE shares code 00 with S00 so the illegal code 10 can never appear.
    function automatic logic [1:0] state_code(input fsm_state_t st);
        case (st)
            S01:     return ST_01;
            S11:     return ST_11;
            default: return ST_00;
        endcase
    endfunction

endpackage

// File: rtl/state_flag_checker.sv
// Compares the decoder's returned flag with the expected mapping for the driven
// code; registers a one-cycle mismatch pulse and a saturating error count.
module state_flag_checker
    import state_spec_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [1:0]       i_code,
    input  logic [1:0]       i_flag,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_cnt
);

    logic             w_flag_err;
    logic             w_err_sat;
    logic             r_mismatch;
    logic [ERR_W-1:0] r_err_cnt;

    // Case inequality so an X/Z flag from the decoder counts as a failure.
    assign w_flag_err = i_valid && (i_flag !== expected_flag(i_code));
    assign w_err_sat  = &r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_mismatch <= w_flag_err;
            if (w_flag_err && !w_err_sat) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/state_spec_driver.sv
// Walks curr_state through 00 -> 01 -> 11 per start pulse with a latched dwell.
// Flag read-back checking is built only when STATE_FLAG_CHECK_EN is defined.
module state_spec_driver
    import state_spec_pkg::*;
#(
    parameter int DWELL_W = 4,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         flag_in,
    output logic [1:0]         curr_state,
    output logic               state_valid,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [ERR_W-1:0]   err_cnt
);

    fsm_state_t         r_state;
    fsm_state_t         w_state_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic               w_done_nxt;
    logic [1:0]         r_code;
    logic               r_busy;
    logic               r_done;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_done_nxt  = 1'b0;
        if (r_state == IDLE) begin
            if (start) begin
                w_state_nxt = S00;
                w_cnt_nxt   = '0;
                w_dwell_nxt = dwell;
            end
        end else if (!hold) begin
            if (r_cnt == r_dwell) begin
                w_cnt_nxt = '0;
                case (r_state)
                    S00: w_state_nxt = S01;
                    S01: w_state_nxt = S11;
                    default: begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                endcase
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_code  <= ST_00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_code  <= state_code(w_state_nxt);
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign curr_state  = r_code;
    assign state_valid = r_busy;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef STATE_FLAG_CHECK_EN
    state_flag_checker #(
        .ERR_W(ERR_W)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (r_busy),
        .i_code    (r_code),
        .i_flag    (flag_in),
        .o_mismatch(mismatch),
        .o_err_cnt (err_cnt)
    );
`else
    logic w_unused_flag;
    assign w_unused_flag = ^flag_in;
    assign mismatch      = 1'b0;
    assign err_cnt       = '0;
`endif

endmodule

// File: tb/tb_state_spec_driver.sv
// Directed bench for state_spec_driver with a cycle model feeding an expected-value queue.
// Expectations follow STATE_FLAG_CHECK_EN when the bench is built with it.
module tb_state_spec_driver;

    localparam int DWELL_W = 4;
    localparam int ERR_W   = 8;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [1:0]         flag_in = 2'b10;
    logic [1:0]         curr_state;
    logic               state_valid;
    logic               busy;
    logic               done;
    logic               mismatch;
    logic [ERR_W-1:0]   err_cnt;

    state_spec_driver #(
        .DWELL_W(DWELL_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
        .dwell      (dwell),
        .flag_in    (flag_in),
        .curr_state (curr_state),
        .state_valid(state_valid),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       code;
        logic             busy;
        logic             done;
        logic             mis;
        logic [ERR_W-1:0] err;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_mis = 0;

`ifdef STATE_FLAG_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Reference model: phase 0 idle, 1..3 for codes 00/01/11, with a down-count of cycles left.
    int         m_phase = 0;
    int         m_left  = 0;
    int         m_dwell = 0;
    logic       m_done  = 1'b0;
    logic       m_mis   = 1'b0;
    int         m_err   = 0;

    // Flag source: 0 = well-behaved decoder, 1 = forced value.
    int         flag_mode  = 0;
    logic [1:0] flag_force = 2'b00;

    int cnt_busy = 0;
    int cnt_s01  = 0;
    int cnt_done = 0;
    int cnt_mm   = 0;

    function automatic logic [1:0] phase_code(input int ph);
        case (ph)
            2:       return 2'b01;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] decoder_flag(input logic [1:0] code);
        if (code == 2'b11) return 2'b00;
        return 2'b10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge();
        logic bad;
        exp_t e;
        if (rst) begin
            m_phase = 0; m_left = 0; m_dwell = 0;
            m_done = 1'b0; m_mis = 1'b0; m_err = 0;
        end else begin
            bad = 1'b0;
            if (CHECK_EN && m_phase != 0) begin
                bad = (flag_in !== decoder_flag(phase_code(m_phase)));
            end
            m_mis = bad;
            if (bad && m_err < ERR_MAX) m_err++;
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (start) begin
                    m_phase = 1;
                    m_dwell = int'(dwell);
                    m_left  = m_dwell + 1;
                end
            end else if (!hold) begin
                if (m_left == 1) begin
                    if (m_phase == 3) begin
                        m_phase = 0;
                        m_done  = 1'b1;
                    end else begin
                        m_phase++;
                        m_left = m_dwell + 1;
                    end
                end else begin
                    m_left--;
                end
            end
        end
        e.code = phase_code(m_phase);
        e.busy = (m_phase != 0);
        e.done = m_done;
        e.mis  = m_mis;
        e.err  = ERR_W'(m_err);
        exp_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        flag_in = (flag_mode == 0) ? decoder_flag(curr_state) : flag_force;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("curr_state", 32'(curr_state), 32'(e.code));
        chk("state_valid", 32'(state_valid), 32'(e.busy));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("mismatch", 32'(mismatch), 32'(e.mis));
        chk("err_cnt", 32'(err_cnt), 32'(e.err));
        n_vec++;
        assert (curr_state !== 2'b10) else begin
            n_mis++;
            $error("FAIL illegal_code observed=%0b expected=not 10", curr_state);
        end
        if (busy) cnt_busy++;
        if (curr_state == 2'b01) cnt_s01++;
        if (done) cnt_done++;
        if (mismatch) cnt_mm++;
    endtask

    task automatic clear_counts();
        cnt_busy = 0; cnt_s01 = 0; cnt_done = 0; cnt_mm = 0;
    endtask

    task automatic run_until_done(input int budget);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (done !== 1'b1 && i < budget);
        chk("done_timeout", 32'(done), 32'(1));
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // dwell=0: one cycle per code, busy 3 cycles, one done pulse.
        clear_counts();
        dwell = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("d0_busy_cycles", 32'(cnt_busy), 32'(3));
        chk("d0_done_pulses", 32'(cnt_done), 32'(1));

        // dwell=3 with 2 hold cycles in S01; dwell input changes mid-sequence.
        clear_counts();
        dwell = 4'd3; start = 1'b1;
        step();
        start = 1'b0; dwell = 4'd0;
        repeat (4) step();
        hold = 1'b1;
        repeat (2) step();
        hold = 1'b0;
        run_until_done(20);
        chk("hold_s01_cycles", 32'(cnt_s01), 32'(6));
        chk("hold_busy_cycles", 32'(cnt_busy), 32'(14));

        // start while busy is ignored; start in the done cycle restarts.
        dwell = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(20);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_code", 32'(curr_state), 32'(0));
        chk("b2b_busy", 32'(busy), 32'(1));
        run_until_done(20);

        // hold in IDLE does not block start.
        hold = 1'b1; dwell = 4'd0; start = 1'b1;
        step();
        start = 1'b0; hold = 1'b0;
        chk("idle_hold_busy", 32'(busy), 32'(1));
        run_until_done(10);

        // Reset during S11 abandons the sequence.
        dwell = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20 && curr_state !== 2'b11; i++) step();
        chk("reach_s11", 32'(curr_state), 32'(3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_code", 32'(curr_state), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err_cnt), 32'(0));
        clear_counts();
        repeat (10) step();
        chk("rst_no_done", 32'(cnt_done), 32'(0));

        // Single forced bad flag during S00.
        clear_counts();
        dwell = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        flag_mode = 1; flag_force = 2'b11;
        step();
        flag_mode = 0;
        chk("force_pulse_next", 32'(mismatch), 32'(CHECK_EN));
        run_until_done(20);
        chk("force_mm_pulses", 32'(cnt_mm), CHECK_EN ? 32'(1) : 32'(0));
        chk("force_err_cnt", 32'(err_cnt), CHECK_EN ? 32'(1) : 32'(0));

        // Stuck flag 01 across back-to-back max-dwell sequences: error counter saturates.
        rst = 1'b1;
        step();
        rst = 1'b0;
        flag_mode = 1; flag_force = 2'b01; dwell = 4'd15;
        for (int s = 0; s < 7; s++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            run_until_done(60);
        end
        chk("sat_err_cnt", 32'(err_cnt), CHECK_EN ? 32'(ERR_MAX) : 32'(0));
        flag_mode = 0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
